ising_observables: RTL and testbench

//  Downstream stage of the Ising lattice peripheral. It streams the lattice one row per beat
//  and computes two observables with periodic boundaries: energy E = -sum_i s_i*sum_nb(s_nb)
//  and magnetisation M = sum_i s_i, where bit 1 means +1 and bit 0 means -1.
//  It emits one result every DECIM frames through a valid/ready output.
//  Row-serial: one row per cycle, no N*N combinational reduction.

---
 rtl/ising_observables.sv | 155 +++++++++++++++
 tb/tb_ising_observables.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_observables.sv
// ising_observables
//   Row-serial observable unit for the Ising lattice peripheral. Streams one
//   lattice row per beat and, with periodic boundaries, accumulates the count
//   of unlike nearest-neighbour bonds (D) and of up spins (ones). When a frame
//   closes it forms
//     energy = 4*D - 4*N*N   (each bond seen from both ends)
//     magnet = 2*ones - N*N
//   and reports every DECIM-th frame over a valid/ready interface.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low; clears all state
//   clear      synchronous flush: drops partial frame, frame counter -> 0
//   row_valid  row_data valid
//   row_ready  a row is accepted this cycle (registered, ACCUM only)
//   row_data   lattice row, bit j = column j, rows in order 0..N-1
//   obs_valid  result valid (held until obs_ready)
//   obs_ready  consumer takes the result
//   energy     signed frame energy
//   magnet     signed frame magnetisation
//   frame_idx  index of the reported frame, wraps at 16 bits
module ising_observables #(
    parameter int N     = 32,
    parameter int DECIM = 4,
    parameter int E_W   = $clog2(4*N*N) + 2,
    parameter int M_W   = $clog2(N*N) + 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           row_valid,
    output logic           row_ready,
    input  logic [N-1:0]   row_data,
    output logic           obs_valid,
    input  logic           obs_ready,
    output logic [E_W-1:0] energy,
    output logic [M_W-1:0] magnet,
    output logic [15:0]    frame_idx
);

    localparam int D_W = $clog2(2*N*N + 1);  // unlike-bond count, max 2*N*N
    localparam int O_W = $clog2(N*N + 1);    // up-spin count, max N*N
    localparam int C_W = $clog2(N);
    localparam int P_W = $clog2(N + 1);

    typedef enum logic [1:0] {ACCUM, FINAL, HOLD} state_t;

    state_t         state;
    logic [C_W-1:0] row_cnt;
    logic [D_W-1:0] d_acc;
    logic [O_W-1:0] ones;
    logic [N-1:0]   first;
    logic [N-1:0]   prev;
    logic [15:0]    frame_cnt;

    function automatic logic [P_W-1:0] popcnt(input logic [N-1:0] v);
        logic [P_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + P_W'(v[i]);
        return c;
    endfunction

    logic           beat;
    logic [N-1:0]   row_rot;
    logic [P_W-1:0] pc_h, pc_v, pc_w, pc_o;
    logic [D_W-1:0] d_fin;
    logic [E_W-1:0] e_fin;
    logic [M_W-1:0] m_fin;
    logic           emit;

    assign beat    = row_valid && row_ready;
    // column wrap: bit j is compared with bit j-1, bit 0 with bit N-1
    assign row_rot = {row_data[N-2:0], row_data[N-1]};
    assign pc_h    = popcnt(row_data ^ row_rot);
    assign pc_v    = popcnt(row_data ^ prev);
    assign pc_o    = popcnt(row_data);
    // row wrap bond between last row (prev) and row 0 (first)
    assign pc_w    = popcnt(prev ^ first);
    assign d_fin   = d_acc + D_W'(pc_w);
    // two's-complement wrap of the subtraction yields the signed result
    assign e_fin   = E_W'({d_fin, 2'b00}) - E_W'(4*N*N);
    assign m_fin   = M_W'({ones, 1'b0}) - M_W'(N*N);
    assign emit    = (32'(frame_cnt) % DECIM) == 0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACCUM;
            row_cnt   <= '0;
            d_acc     <= '0;
            ones      <= '0;
            first     <= '0;
            prev      <= '0;
            frame_cnt <= '0;
            frame_idx <= '0;
            row_ready <= 1'b0;
            obs_valid <= 1'b0;
            energy    <= '0;
            magnet    <= '0;
        end else if (clear) begin
            // wins over a simultaneous beat; energy/magnet keep last value
            state     <= ACCUM;
            row_cnt   <= '0;
            d_acc     <= '0;
            ones      <= '0;
            frame_cnt <= '0;
            frame_idx <= '0;
            row_ready <= 1'b1;
            obs_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    row_ready <= 1'b1;
                    if (beat) begin
                        ones  <= ones + O_W'(pc_o);
                        d_acc <= d_acc + D_W'(pc_h)
                                 + ((row_cnt != '0) ? D_W'(pc_v) : '0);
                        prev  <= row_data;
                        if (row_cnt == '0) first <= row_data;
                        if (row_cnt == C_W'(N-1)) begin
                            row_cnt   <= '0;
                            row_ready <= 1'b0;
                            state     <= FINAL;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                FINAL: begin
                    if (emit) begin
                        energy    <= e_fin;
                        magnet    <= m_fin;
                        frame_idx <= frame_cnt;
                        obs_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        row_ready <= 1'b1;
                        state     <= ACCUM;
                    end
                    d_acc     <= '0;
                    ones      <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end
                HOLD: begin
                    if (obs_ready) begin
                        obs_valid <= 1'b0;
                        row_ready <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_ising_observables.sv
// Testbench for ising_observables: directed frames plus randomized frames and
// row gaps, checked against a site-by-site neighbour-sum model of the lattice.
module tb_ising_observables;

    localparam int N     = 32;
    localparam int DECIM = 4;
    localparam int E_W   = 14;
    localparam int M_W   = 12;

    logic           clk = 1'b0;
    logic           reset, clear, row_valid, row_ready, obs_valid, obs_ready;
    logic [N-1:0]   row_data;
    logic [E_W-1:0] energy;
    logic [M_W-1:0] magnet;
    logic [15:0]    frame_idx;

    ising_observables #(.N(N), .DECIM(DECIM), .E_W(E_W), .M_W(M_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .obs_valid(obs_valid), .obs_ready(obs_ready),
        .energy(energy), .magnet(magnet), .frame_idx(frame_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int e; int m; int idx; int rise; } res_t;
    res_t got[$];
    res_t expq[$];

    int chk = 0, err = 0;
    logic [N-1:0] fr [N];
    int fidx = 0;
    int last_beat = 0;
    int gap_pct = 0;
    bit rnd_ready = 0;

    // output monitor: records the cycle obs_valid first shows and each handshake
    logic ov_d = 1'b0;
    int   rise = 0;
    always @(posedge clk) begin
        res_t r;
        if (obs_valid && !ov_d) rise = cyc;
        ov_d = obs_valid;
        if (obs_valid && obs_ready) begin
            r.e = $signed(energy);
            r.m = $signed(magnet);
            r.idx = int'(frame_idx);
            r.rise = rise;
            got.push_back(r);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // spin model: E = -sum s_i * (four neighbours), M = sum s_i, torus wrap
    function automatic void model(output int e, output int m);
        int s, nb;
        e = 0; m = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s  = fr[i][j] ? 1 : -1;
                nb = (fr[i][(j+1)%N] ? 1 : -1) + (fr[i][(j+N-1)%N] ? 1 : -1)
                   + (fr[(i+1)%N][j] ? 1 : -1) + (fr[(i+N-1)%N][j] ? 1 : -1);
                e -= s * nb;
                m += s;
            end
    endfunction

    task automatic drive_row(input logic [N-1:0] d);
        bit acc = 0;
        int gaps = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
        repeat (gaps) begin
            @(negedge clk);
            row_valid = 1'b0;
            row_data  = $urandom;
            if (rnd_ready) obs_ready = ($urandom_range(3) != 0);
        end
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            row_valid = 1'b1;
            row_data  = d;
            if (rnd_ready) obs_ready = ($urandom_range(3) != 0);
            acc = row_ready && !clear;
            @(posedge clk);
            if (acc) last_beat = cyc;
        end
        #1;
        row_valid = 1'b0;
        row_data  = $urandom;
        if (!acc) check("row_accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int nrows);
        res_t x;
        for (int r = 0; r < nrows; r++) drive_row(fr[r]);
        if (nrows == N) begin
            if (fidx % DECIM == 0) begin
                model(x.e, x.m);
                x.idx  = fidx;
                x.rise = last_beat + 2;
                expq.push_back(x);
            end
            fidx = (fidx + 1) % 65536;
        end
    endtask

    task automatic check_results(input string tag);
        res_t g, x;
        obs_ready = 1'b1;
        rnd_ready = 0;
        for (int k = 0; k < 400 && got.size() < expq.size(); k++) @(negedge clk);
        repeat (6) @(negedge clk);
        check({tag, "_count"}, got.size(), expq.size());
        while (got.size() > 0 && expq.size() > 0) begin
            g = got.pop_front();
            x = expq.pop_front();
            check({tag, "_energy"}, g.e, x.e);
            check({tag, "_magnet"}, g.m, x.m);
            check({tag, "_idx"}, g.idx, x.idx);
            check({tag, "_latency"}, g.rise, x.rise);
        end
        got.delete();
        expq.delete();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        fidx = 0;
    endtask

    task automatic rand_frame();
        for (int r = 0; r < N; r++) fr[r] = $urandom;
    endtask

    initial begin
        int e6, m6;
        reset = 1'b0; clear = 1'b0; row_valid = 1'b0; obs_ready = 1'b1;
        row_data = '0;
        repeat (3) @(negedge clk);
        check("rst_row_ready", row_ready, 0);
        check("rst_obs_valid", obs_valid, 0);
        check("rst_energy", int'(energy), 0);
        check("rst_magnet", int'(magnet), 0);
        check("rst_frame_idx", int'(frame_idx), 0);
        reset = 1'b1;
        #1 check("rel_row_ready_low", row_ready, 0);
        @(negedge clk);
        check("rel_row_ready_high", row_ready, 1);

        // all ones
        for (int r = 0; r < N; r++) fr[r] = '1;
        send_frame(N);
        check_results("t1_ones");

        // checkerboard
        do_clear();
        for (int r = 0; r < N; r++) fr[r] = (r % 2 == 0) ? 32'hAAAAAAAA : 32'h55555555;
        send_frame(N);
        check_results("t2_checker");

        // one flipped spin
        do_clear();
        for (int r = 0; r < N; r++) fr[r] = '1;
        fr[5] = 32'hFFFFFFFE;
        send_frame(N);
        check_results("t3_flip");

        // half up / half down, row wrap bond counted
        do_clear();
        for (int r = 0; r < N; r++) fr[r] = (r < 16) ? '1 : '0;
        send_frame(N);
        check_results("t4_half");

        // decimation: five frames give frames 0 and 4
        do_clear();
        gap_pct = 30;
        for (int r = 0; r < N; r++) fr[r] = '0;
        repeat (5) send_frame(N);
        check_results("t5_decim");

        // random frames, random gaps and random backpressure
        do_clear();
        gap_pct = 40;
        rnd_ready = 1;
        for (int f = 0; f < 9; f++) begin
            rand_frame();
            send_frame(N);
        end
        check_results("rand");

        // mid-frame clear discards the partial frame
        do_clear();
        rand_frame();
        send_frame(10);
        do_clear();
        rand_frame();
        send_frame(N);
        check_results("midclear");

        // clear while holding a result drops obs_valid without handshake
        do_clear();
        obs_ready = 1'b0;
        rand_frame();
        send_frame(N);
        for (int k = 0; k < 50 && !obs_valid; k++) @(negedge clk);
        check("holdclr_valid", obs_valid, 1);
        do_clear();
        check("holdclr_dropped", obs_valid, 0);
        expq.delete();
        obs_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("holdclr_no_result", got.size(), 0);

        // backpressure: outputs stable, no rows taken while held
        do_clear();
        obs_ready = 1'b0;
        rand_frame();
        send_frame(N);
        model(e6, m6);
        for (int k = 0; k < 50 && !obs_valid; k++) @(negedge clk);
        check("bp_valid", obs_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            row_valid = 1'b1;
            row_data  = $urandom;
            check("bp_row_ready", row_ready, 0);
            check("bp_obs_valid", obs_valid, 1);
            check("bp_energy", $signed(energy), e6);
            check("bp_magnet", $signed(magnet), m6);
            check("bp_idx", int'(frame_idx), 0);
        end
        row_valid = 1'b0;
        check_results("bp");

        // reset during the next frame, then a full frame restarts at index 0
        rand_frame();
        send_frame(17);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_row_ready", row_ready, 0);
        check("mrst_obs_valid", obs_valid, 0);
        check("mrst_energy", int'(energy), 0);
        check("mrst_magnet", int'(magnet), 0);
        check("mrst_frame_idx", int'(frame_idx), 0);
        @(negedge clk);
        reset = 1'b1;
        fidx = 0;
        rand_frame();
        send_frame(N);
        check_results("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
